// File: rtl/lms_capture_pkg.sv
// lms_capture_pkg
// Shared definitions for the LMS7002M RX capture writer:
//   - state_e        : capture controller states
//   - DEFAULT_*      : default memory geometry and sample width
//   - DECIM_W        : width of the optional decimation factor
//   - pack_iq()      : sign-extends I and Q to 16 bits and packs {Q, I}
package lms_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int DEFAULT_MEM_DEPTH = 2500;
    localparam int DEFAULT_ADDR_W    = 12;
    localparam int DEFAULT_SAMPLE_W  = 12;
    localparam int DECIM_W           = 8;

    // Samples arrive zero-padded to 16 bits; shifting the sign bit to bit 15
    // and arithmetic-shifting back restores the two's complement value.
    // sample_w must be in 1..16.
    function automatic logic [31:0] pack_iq(input logic [15:0] i_raw,
                                            input logic [15:0] q_raw,
                                            input int          sample_w);
        logic [15:0] i_ext;
        logic [15:0] q_ext;
        int          sh;
        sh    = 16 - sample_w;
        i_ext = 16'($signed(i_raw << sh) >>> sh);
        q_ext = 16'($signed(q_raw << sh) >>> sh);
        return {q_ext, i_ext};
    endfunction

endpackage

// File: rtl/lms_capture_decim.sv
// lms_capture_decim
// Phase counter for sample decimation: keep_o is high for the first of
// every (decim_i+1) advanced samples. Only built with LMS_CAPTURE_DECIM_EN.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   clear_i   in   restart phase at zero (capture start)
//   advance_i in   one sample consumed this cycle
//   decim_i   in   decimation factor minus one
//   keep_o    out  current sample is to be written
module lms_capture_decim
    import lms_capture_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic [DECIM_W-1:0] decim_i,
    output logic               keep_o
);

    logic [DECIM_W-1:0] phase_q;
    logic [DECIM_W-1:0] phase_d;

    assign keep_o = (phase_q == '0);

    always_comb begin
        phase_d = phase_q;
        if (clear_i) begin
            phase_d = '0;
        end else if (advance_i) begin
            phase_d = (phase_q == decim_i) ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/lms_rx_capture_writer.sv
// lms_rx_capture_writer
// Accepts LMS7002M RX I/Q samples on a valid/ready stream, packs each pair
// into {sext16(Q), sext16(I)} and writes it to an Avalon-MM memory slave.
// Single-shot or ring capture of a programmed length.
// Optional feature macro: LMS_CAPTURE_DECIM_EN (adds the decim input).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, stop                one-cycle control pulses
//   ring_mode, base_addr,
//   length, [decim]            capture setup, sampled at start
//   s_valid/s_ready/s_i/s_q    sample stream
//   m_address, m_chipselect,
//   m_write, m_byteenable,
//   m_writedata                memory write port (no waitrequest)
//   busy, done, wr_count,
//   overrun                    status
module lms_rx_capture_writer
    import lms_capture_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int SAMPLE_W  = DEFAULT_SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                ring_mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   length,
`ifdef LMS_CAPTURE_DECIM_EN
    input  logic [DECIM_W-1:0]  decim,
`endif
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_i,
    input  logic [SAMPLE_W-1:0] s_q,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [3:0]          m_byteenable,
    output logic [31:0]         m_writedata,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   wr_count,
    output logic                overrun
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   wr_count_q, wr_count_d;
    logic [ADDR_W-1:0]   m_address_q, m_address_d;
    logic [31:0]         m_writedata_q, m_writedata_d;
    logic                m_write_q, m_write_d;
    logic                ring_q, ring_d;
    logic                overrun_q, overrun_d;
    // finish_q: the capture has ended (last write issued, stop seen, or
    // zero length). CAPTURE lingers one cycle with s_ready low so the final
    // write is on the bus before DONE, and busy stays high until done.
    logic                finish_q, finish_d;

    logic                start_accept;
    logic                accept;
    logic                keep;
    logic [ADDR_W-1:0]   base_mod;
    logic [ADDR_W-1:0]   len_clamp;
    logic [ADDR_W-1:0]   ptr_next;
    logic [ADDR_W-1:0]   cnt_inc;

    assign start_accept = (state_q == ST_IDLE) && start;
    assign s_ready      = (state_q == ST_CAPTURE) && !finish_q;
    assign accept       = s_valid && s_ready;

    assign base_mod  = ADDR_W'(32'(base_addr) % 32'(MEM_DEPTH));
    assign len_clamp = (32'(length) > 32'(MEM_DEPTH)) ? ADDR_W'(MEM_DEPTH) : length;
    assign ptr_next  = (ptr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign cnt_inc   = wr_count_q + 1'b1;

`ifdef LMS_CAPTURE_DECIM_EN
    logic [DECIM_W-1:0] decim_q, decim_d;

    lms_capture_decim u_decim (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (start_accept),
        .advance_i (accept),
        .decim_i   (decim_q),
        .keep_o    (keep)
    );
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        ptr_d         = ptr_q;
        wr_count_d    = wr_count_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        m_write_d     = 1'b0;
        ring_d        = ring_q;
        overrun_d     = overrun_q;
        finish_d      = finish_q;
`ifdef LMS_CAPTURE_DECIM_EN
        decim_d       = decim_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d     = base_mod;
                    len_d      = len_clamp;
                    ring_d     = ring_mode;
                    ptr_d      = base_mod;
                    wr_count_d = '0;
                    overrun_d  = 1'b0;
                    finish_d   = (len_clamp == '0);
`ifdef LMS_CAPTURE_DECIM_EN
                    decim_d    = decim;
`endif
                    state_d    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (finish_q) begin
                    state_d = ST_DONE;
                end else begin
                    if (accept && keep) begin
                        m_write_d     = 1'b1;
                        m_address_d   = ptr_q;
                        m_writedata_d = pack_iq(16'(s_i), 16'(s_q), SAMPLE_W);
                        if (cnt_inc == len_q) begin
                            if (ring_q) begin
                                // Ring pass complete: restart at base.
                                wr_count_d = '0;
                                overrun_d  = 1'b1;
                                ptr_d      = base_q;
                            end else begin
                                wr_count_d = cnt_inc;
                                ptr_d      = ptr_next;
                                finish_d   = 1'b1;
                            end
                        end else begin
                            wr_count_d = cnt_inc;
                            ptr_d      = ptr_next;
                        end
                    end
                    if (stop) begin
                        finish_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                finish_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            ptr_q         <= '0;
            wr_count_q    <= '0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            m_write_q     <= 1'b0;
            ring_q        <= 1'b0;
            overrun_q     <= 1'b0;
            finish_q      <= 1'b0;
`ifdef LMS_CAPTURE_DECIM_EN
            decim_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            ptr_q         <= ptr_d;
            wr_count_q    <= wr_count_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            m_write_q     <= m_write_d;
            ring_q        <= ring_d;
            overrun_q     <= overrun_d;
            finish_q      <= finish_d;
`ifdef LMS_CAPTURE_DECIM_EN
            decim_q       <= decim_d;
`endif
        end
    end

    assign busy         = (state_q == ST_CAPTURE);
    assign done         = (state_q == ST_DONE);
    assign m_write      = m_write_q;
    assign m_chipselect = m_write_q;
    assign m_byteenable = {4{m_write_q}};
    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign wr_count     = wr_count_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/lms_rx_capture_writer.md
# lms_rx_capture_writer

Capture engine upstream of the Nios on-chip data memory: accepts LMS7002M RX I/Q samples on a valid/ready stream, packs each pair into one 32-bit word and writes it into the memory's Avalon-MM slave port. It runs as a single-shot or ring-buffer capture of a programmed length. Software then reads the captured words back from the data memory through the memory's other port.

## Interface
Parameters:
- MEM_DEPTH, 2500, number of 32-bit words in the target memory; address wraps modulo this value.
- ADDR_W, 12, memory word-address width.
- SAMPLE_W, 12, I and Q sample width (two's complement).

Ports:
- clk  in  1  single clock for the block and the memory.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a capture. Ignored unless idle.
- stop  in  1  one-cycle pulse; ends a ring capture. Ignored when idle.
- ring_mode  in  1  sampled at start: 0 = single-shot, 1 = ring.
- base_addr  in  ADDR_W  first word address; sampled at start.
- length  in  ADDR_W  words per pass; sampled at start.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- s_i  in  SAMPLE_W  in-phase sample.
- s_q  in  SAMPLE_W  quadrature sample.
- m_address  out  ADDR_W  memory word address.
- m_chipselect  out  1  memory select.
- m_write  out  1  memory write strobe.
- m_byteenable  out  4  always 4'hF when m_write=1, else 4'h0.
- m_writedata  out  32  packed sample word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- wr_count  out  ADDR_W  words written in the current pass.
- overrun  out  1  sticky; set on ring wrap; cleared by start or reset.

## Operation
- States:
  - IDLE: s_ready=0. On start, latch base_addr, ring_mode and length (clamp length to MEM_DEPTH; base_addr ≥ MEM_DEPTH is reduced modulo MEM_DEPTH). Go to CAPTURE; length=0 goes straight to DONE.
  - CAPTURE: s_ready=1. Each accepted sample (after decimation, if compiled in) issues one write.
  - DONE: done=1 for one cycle, then IDLE.
- Packing: m_writedata = {sext16(s_q), sext16(s_i)}.
- Address: ptr starts at base; ptr ← (ptr==MEM_DEPTH-1) ? 0 : ptr+1 after each write.
- wr_count increments per write.
  - When it reaches length in single-shot mode: go to DONE.
  - In ring mode: wr_count←0, set overrun, continue.
- stop in CAPTURE: the current accepted sample, if any, is still written; then go to DONE.
- s_valid in IDLE or DONE is not consumed; the sample is simply not accepted, and no error is raised.

## Timing
- Reset values: s_ready=0, m_write=0, m_chipselect=0, m_address=0, m_byteenable=0, m_writedata=0, busy=0, done=0, wr_count=0, overrun=0, state=IDLE.
- Write latency: the memory write appears registered one cycle after acceptance. m_chipselect=m_write for that cycle, and the memory has no waitrequest. Sustained rate is one word per cycle.
- busy rises the cycle after start and falls in the same cycle done pulses.
- The last write of a single-shot capture is on the bus in the cycle before done.
- stop and the final-length write in the same cycle: one DONE, one done pulse.
- start in the same cycle as reset: reset wins.
- Reset mid-capture: the in-flight write is dropped and all outputs return to their reset values the next cycle.

## Configuration
- LMS_CAPTURE_DECIM_EN defined:
  - Adds input decim (8 bits, sampled at start).
  - Only every (decim+1)-th accepted sample is written; the others are accepted and discarded.
  - The phase counter clears at start.
- LMS_CAPTURE_DECIM_EN undefined: no decim port, and every accepted sample is written.

## Structure
- Package lms_capture_pkg holds:
  - state enum (IDLE, CAPTURE, DONE);
  - default MEM_DEPTH and ADDR_W constants;
  - the sign-extend/pack function.
- Sub-module lms_capture_decim (phase counter producing a keep strobe) is instantiated only under LMS_CAPTURE_DECIM_EN.

## Test plan
- Single-shot: base=0, length=4, samples I=1..4, Q=-1..-4 continuous → writes at addr 0..3, data 0xFFFF0001…0xFFFC0004, done 1 cycle after last write, overrun=0.
- Wrap: base=2498, length=4 → writes at 2498, 2499, 0, 1; wr_count ends at 4.
- Ring + stop: ring_mode=1, base=10, length=3, 8 samples then stop → addresses 10,11,12,10,11,12,10,11, overrun=1, exactly one done pulse.
- Backpressure/gaps: s_valid toggled every other cycle, length=5 → exactly 5 writes, none on idle cycles, s_ready=0 after DONE.
- Reset mid-capture: assert reset after 2 of 6 writes → m_write=0 next cycle, busy=0, wr_count=0; a new start at base=100 writes from 100.
- Edge inputs: length=0 → done the cycle after busy rises, no writes. length=4000 → clamped to 2500 words. With LMS_CAPTURE_DECIM_EN and decim=2: 9 samples produce 3 writes (samples 1, 4, 7).
